// File: rtl/scan_window_scheduler.sv
// -----------------------------------------------------------------------------
// scan_window_scheduler
//
// Sequences the Viola-Jones window scan over every pyramid level once a new
// laptop image has been written to pyramid level 0. The block waits a fixed
// settle time for the integral images, then walks img_index/row_index/
// col_index over every legal window position. It issues one window per
// accepted handshake into vj_pipeline. After the last window it waits for
// the pipeline to drain and pulses scan_done.
//
// Handshake: a window is transferred on a rising clock edge where both
// win_valid and win_ready are high. While win_valid is high and win_ready is
// low, img_index/row_index/col_index hold steady. win_ready has no effect
// while win_valid is low.
//
// Ports:
//   clock           system clock
//   reset_n         asynchronous active-low reset
//   laptop_img_rdy  one-cycle pulse: a new image has been written to level 0
//   win_ready       vj_pipeline accepts the presented window this cycle
//   pipe_idle       vj_pipeline holds no windows in flight
//   win_valid       img_index/row_index/col_index form a valid window
//   img_index       current pyramid level (4'd15 when not scanning)
//   row_index       window top row
//   col_index       window left column
//   busy            high in every state except IDLE
//   scan_done       one-cycle pulse when the scan is complete and drained
//   win_count       (SCAN_WIN_COUNT_EN only) number of windows accepted
//                   since the last image was accepted
//   state_dbg_o     current FSM state (0 IDLE, 1 SETTLE, 2 SCAN, 3 DRAIN)
//
// Optional feature: define SCAN_WIN_COUNT_EN to add the win_count output.
// -----------------------------------------------------------------------------

`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd52, 32'd66, 32'd83, 32'd104, 32'd130, 32'd163, 32'd204, 32'd256, 32'd320}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd39, 32'd49, 32'd62, 32'd78, 32'd97, 32'd122, 32'd153, 32'd192, 32'd240}
`endif

module scan_window_scheduler #(
    parameter int                                PYRAMID_LEVELS  = 9,
    parameter int                                WINDOW_SIZE     = 24,
    parameter logic [PYRAMID_LEVELS-1:0][31:0]   PYRAMID_WIDTHS  = `PYRAMID_WIDTHS,
    parameter logic [PYRAMID_LEVELS-1:0][31:0]   PYRAMID_HEIGHTS = `PYRAMID_HEIGHTS,
    parameter int                                SETTLE_CYCLES   = 10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        laptop_img_rdy,
    input  logic        win_ready,
    input  logic        pipe_idle,
    output logic        win_valid,
    output logic [3:0]  img_index,
    output logic [31:0] row_index,
    output logic [31:0] col_index,
    output logic        busy,
    output logic        scan_done,
`ifdef SCAN_WIN_COUNT_EN
    output logic [31:0] win_count,
`endif
    output logic [1:0]  state_dbg_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SCAN   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    localparam logic [3:0] IMG_NONE = 4'd15;

    state_t      state_q, state_d;
    logic [31:0] settle_q, settle_d;
    logic [3:0]  img_q, img_d;
    logic [31:0] row_q, row_d;
    logic [31:0] col_q, col_d;

    // Limits of the level currently addressed by img_q.
    logic [31:0] lvl_w;
    logic [31:0] lvl_h;
    logic        level_ok;
    logic [31:0] col_last;
    logic [31:0] row_last;
    logic        last_level;
    logic        accept;

    always_comb begin
        lvl_w = '0;
        lvl_h = '0;
        for (int i = 0; i < PYRAMID_LEVELS; i++) begin
            if (img_q == 4'(i)) begin
                lvl_w = PYRAMID_WIDTHS[i];
                lvl_h = PYRAMID_HEIGHTS[i];
            end
        end
    end

    // A level too small for even one window is skipped; its limits below
    // would underflow, but they are never used when level_ok is low.
    assign level_ok   = (lvl_w > 32'(WINDOW_SIZE)) && (lvl_h > 32'(WINDOW_SIZE));
    assign col_last   = lvl_w - 32'(WINDOW_SIZE) - 32'd1;
    assign row_last   = lvl_h - 32'(WINDOW_SIZE) - 32'd1;
    assign last_level = (img_q == 4'(PYRAMID_LEVELS - 1));
    assign accept     = win_valid && win_ready;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            img_q    <= IMG_NONE;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            img_q    <= img_d;
            row_q    <= row_d;
            col_q    <= col_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        img_d    = img_q;
        row_d    = row_q;
        col_d    = col_q;

        unique case (state_q)
            S_IDLE: begin
                if (laptop_img_rdy) begin
                    state_d  = S_SETTLE;
                    settle_d = 32'd1;
                end
            end

            S_SETTLE: begin
                if (settle_q == 32'(SETTLE_CYCLES)) begin
                    state_d  = S_SCAN;
                    settle_d = '0;
                    img_d    = 4'd0;
                    row_d    = '0;
                    col_d    = '0;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end

            S_SCAN: begin
                // Advance within the level on an accept; a degenerate level
                // moves on in its first cycle without presenting a window.
                if (level_ok && accept && (col_q < col_last)) begin
                    col_d = col_q + 32'd1;
                end else if (level_ok && accept && (row_q < row_last)) begin
                    col_d = '0;
                    row_d = row_q + 32'd1;
                end else if (!level_ok || accept) begin
                    row_d = '0;
                    col_d = '0;
                    if (last_level) begin
                        state_d = S_DRAIN;
                        img_d   = IMG_NONE;
                    end else begin
                        img_d = img_q + 4'd1;
                    end
                end
            end

            S_DRAIN: begin
                if (pipe_idle) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    always_comb begin
        win_valid   = (state_q == S_SCAN) && level_ok;
        busy        = (state_q != S_IDLE);
        scan_done   = (state_q == S_DRAIN) && pipe_idle;
        img_index   = img_q;
        row_index   = row_q;
        col_index   = col_q;
        state_dbg_o = state_q;
    end

`ifdef SCAN_WIN_COUNT_EN
    logic [31:0] count_q, count_d;

    // Cleared only when a new image is accepted, so the total survives
    // scan_done until the next scan starts.
    always_comb begin
        count_d = count_q;
        if ((state_q == S_IDLE) && laptop_img_rdy) begin
            count_d = '0;
        end else if (accept) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign win_count = count_q;
`endif

endmodule

// File: tb/tb_scan_window_scheduler.sv
// -----------------------------------------------------------------------------
// tb_scan_window_scheduler
//
// Two scheduler instances share the bench inputs: dut_a scans a 2-level
// pyramid (30x28, 26x25) and dut_b one whose second level is too narrow
// (30x28, 24x25). Only the selected instance sees laptop_img_rdy.
// The expected window sequence comes from nested loops over the legal
// positions of each level and is queued in exp_q before each scan.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_scan_window_scheduler;

    localparam int LEVELS = 2;
    localparam int WS     = 24;
    localparam int SETTLE = 10;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SCAN   = 2'd2;
    localparam logic [1:0] ST_DRAIN  = 2'd3;

    localparam logic [LEVELS-1:0][31:0] A_WIDTHS  = {32'd26, 32'd30};
    localparam logic [LEVELS-1:0][31:0] B_WIDTHS  = {32'd24, 32'd30};
    localparam logic [LEVELS-1:0][31:0] HEIGHTS   = {32'd25, 32'd28};

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic rdy       = 1'b0;
    logic sel       = 1'b0;
    logic win_ready = 1'b0;
    logic pipe_idle = 1'b1;
    logic rdy_a, rdy_b;
    assign rdy_a = rdy & ~sel;
    assign rdy_b = rdy & sel;

    logic        a_valid, b_valid, a_busy, b_busy, a_done, b_done;
    logic [3:0]  a_img, b_img;
    logic [31:0] a_row, b_row, a_col, b_col;
    logic [1:0]  a_state, b_state;
`ifdef SCAN_WIN_COUNT_EN
    logic [31:0] a_count, b_count;
`endif

    scan_window_scheduler #(
        .PYRAMID_LEVELS(LEVELS), .WINDOW_SIZE(WS),
        .PYRAMID_WIDTHS(A_WIDTHS), .PYRAMID_HEIGHTS(HEIGHTS),
        .SETTLE_CYCLES(SETTLE)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .laptop_img_rdy(rdy_a),
        .win_ready(win_ready), .pipe_idle(pipe_idle),
        .win_valid(a_valid), .img_index(a_img), .row_index(a_row),
        .col_index(a_col), .busy(a_busy), .scan_done(a_done),
`ifdef SCAN_WIN_COUNT_EN
        .win_count(a_count),
`endif
        .state_dbg_o(a_state)
    );

    scan_window_scheduler #(
        .PYRAMID_LEVELS(LEVELS), .WINDOW_SIZE(WS),
        .PYRAMID_WIDTHS(B_WIDTHS), .PYRAMID_HEIGHTS(HEIGHTS),
        .SETTLE_CYCLES(SETTLE)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .laptop_img_rdy(rdy_b),
        .win_ready(win_ready), .pipe_idle(pipe_idle),
        .win_valid(b_valid), .img_index(b_img), .row_index(b_row),
        .col_index(b_col), .busy(b_busy), .scan_done(b_done),
`ifdef SCAN_WIN_COUNT_EN
        .win_count(b_count),
`endif
        .state_dbg_o(b_state)
    );

    // Observed instance.
    logic        obs_valid, obs_busy, obs_done;
    logic [3:0]  obs_img;
    logic [31:0] obs_row, obs_col;
    logic [1:0]  obs_state;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_done  = sel ? b_done  : a_done;
    assign obs_img   = sel ? b_img   : a_img;
    assign obs_row   = sel ? b_row   : a_row;
    assign obs_col   = sel ? b_col   : a_col;
    assign obs_state = sel ? b_state : a_state;
`ifdef SCAN_WIN_COUNT_EN
    logic [31:0] obs_count;
    assign obs_count = sel ? b_count : a_count;
`endif

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    logic [67:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;
    int acc_cnt = 0;
    int done_cnt = 0;
    bit mon_en = 1'b0;
    bit hold_pend = 1'b0;
    logic [67:0] hold_win = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic timeout_fail(input string name);
        n_total++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: samples on the falling edge, between input updates and the
    // edge that acts on them.
    always @(negedge clock) begin
        if (mon_en) begin
            if (hold_pend) begin
                check("hold_stable", 128'({obs_valid, obs_img, obs_row, obs_col}),
                      128'({1'b1, hold_win}));
            end
            if (obs_valid && win_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL extra_window: got %0h expected none",
                             {obs_img, obs_row, obs_col});
                end else begin
                    check("window", 128'({obs_img, obs_row, obs_col}), 128'(exp_q.pop_front()));
                end
                acc_cnt++;
            end
            hold_pend = obs_valid && !win_ready;
            hold_win  = {obs_img, obs_row, obs_col};
            if (obs_done) done_cnt++;
        end
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference sequence: every legal (level,row,col) in scan order.
    task automatic fill_model(input bit use_b);
        int unsigned mw[LEVELS];
        int unsigned mh[LEVELS];
        mw[0] = 30; mw[1] = use_b ? 24 : 26;
        mh[0] = 28; mh[1] = 25;
        exp_q.delete();
        for (int l = 0; l < LEVELS; l++) begin
            if (mw[l] > WS && mh[l] > WS) begin
                for (int unsigned r = 0; r + WS < mh[l]; r++) begin
                    for (int unsigned c = 0; c + WS < mw[l]; c++) begin
                        exp_q.push_back({4'(l), 32'(r), 32'(c)});
                    end
                end
            end
        end
    endtask

    typedef struct {
        bit       use_b;
        bit [3:0] pat;          // win_ready pattern, bit i used on cycle i%4
        int       drain_hold;   // cycles pipe_idle stays low in DRAIN
        bit       restart;      // extra rdy pulses in SETTLE and mid-SCAN
        bit       rdy_at_exit;  // rdy pulse on the DRAIN->IDLE cycle
        int       exp_windows;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int  n;
        int  guard;
        bit  pulsed;
        sel       = v.use_b;
        fill_model(v.use_b);
        acc_cnt   = 0;
        done_cnt  = 0;
        hold_pend = 1'b0;
        win_ready = v.pat[0];
        pipe_idle = (v.drain_hold == 0);
        mon_en    = 1'b1;

        rdy = 1'b1;
        step();
        rdy = 1'b0;
        n = 1;
        while (!obs_valid && n < 200) begin
            rdy = v.restart && (n == 5);
            step();
            n++;
        end
        rdy = 1'b0;
        check("first_latency", 128'(n), 128'(SETTLE + 1));
`ifdef SCAN_WIN_COUNT_EN
        check("count_start", 128'(obs_count), 128'(0));
`endif

        guard  = 0;
        pulsed = 1'b0;
        while (exp_q.size() > 0 && guard < 5000) begin
            win_ready = v.pat[guard % 4];
            rdy = v.restart && !pulsed && (acc_cnt == 10);
            if (rdy) pulsed = 1'b1;
            step();
            guard++;
        end
        rdy = 1'b0;
        if (exp_q.size() > 0) timeout_fail("scan_windows");

        guard = 0;
        while (obs_state == ST_SCAN && guard < 50) begin
            step();
            guard++;
        end
        check("enter_drain", 128'({obs_state, obs_valid, obs_img}), 128'({ST_DRAIN, 1'b0, 4'd15}));

        for (int k = 0; k < v.drain_hold; k++) begin
            check("drain_hold", 128'({obs_state, obs_busy, obs_done}), 128'({ST_DRAIN, 1'b1, 1'b0}));
            step();
        end
        pipe_idle = 1'b1;
        rdy = v.rdy_at_exit;
        #1;
        check("done_pulse", 128'({obs_done, obs_busy}), 128'({1'b1, 1'b1}));
        step();
        rdy = 1'b0;
        check("idle_after", 128'({obs_state, obs_busy, obs_done, obs_img}),
              128'({ST_IDLE, 1'b0, 1'b0, 4'd15}));
        win_ready = 1'b0;
        repeat (3) step();
        check("still_idle", 128'({obs_state, obs_busy}), 128'({ST_IDLE, 1'b0}));
        check("done_count", 128'(done_cnt), 128'(1));
        check("accept_count", 128'(acc_cnt), 128'(v.exp_windows));
`ifdef SCAN_WIN_COUNT_EN
        check("win_count", 128'(obs_count), 128'(v.exp_windows));
`endif
        mon_en = 1'b0;
    endtask

    // ---------------------------------------------------------------------
    // Test
    // ---------------------------------------------------------------------
    vec_t vecs[5];

    initial begin
        int guard;
        vecs[0] = '{use_b: 1'b0, pat: 4'b1111, drain_hold: 0,  restart: 1'b0, rdy_at_exit: 1'b0, exp_windows: 26};
        vecs[1] = '{use_b: 1'b0, pat: 4'b1001, drain_hold: 0,  restart: 1'b0, rdy_at_exit: 1'b0, exp_windows: 26};
        vecs[2] = '{use_b: 1'b0, pat: 4'b1111, drain_hold: 20, restart: 1'b0, rdy_at_exit: 1'b1, exp_windows: 26};
        vecs[3] = '{use_b: 1'b0, pat: 4'b1011, drain_hold: 0,  restart: 1'b1, rdy_at_exit: 1'b0, exp_windows: 26};
        vecs[4] = '{use_b: 1'b1, pat: 4'b1111, drain_hold: 0,  restart: 1'b0, rdy_at_exit: 1'b0, exp_windows: 24};

        // Reset values.
        reset_n = 1'b0;
        repeat (2) step();
        check("reset_a", 128'({a_state, a_valid, a_busy, a_done, a_img, a_row, a_col}),
              128'({ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd15, 32'd0, 32'd0}));
        check("reset_b", 128'({b_state, b_valid, b_busy, b_done, b_img}),
              128'({ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd15}));
`ifdef SCAN_WIN_COUNT_EN
        check("reset_count", 128'(a_count), 128'(0));
`endif
        reset_n = 1'b1;
        step();

        // win_ready without a valid window does nothing.
        win_ready = 1'b1;
        repeat (3) step();
        check("idle_ready", 128'({a_state, a_valid, a_busy}), 128'({ST_IDLE, 1'b0, 1'b0}));
        win_ready = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset mid-scan at level 0 row 2.
        sel = 1'b0;
        mon_en = 1'b0;
        win_ready = 1'b1;
        pipe_idle = 1'b1;
        rdy = 1'b1;
        step();
        rdy = 1'b0;
        guard = 0;
        while (!(a_valid && a_img == 4'd0 && a_row == 32'd2) && guard < 300) begin
            step();
            guard++;
        end
        if (guard >= 300) timeout_fail("reach_row2");
        check("midscan_busy", 128'({a_state, a_busy}), 128'({ST_SCAN, 1'b1}));
        reset_n = 1'b0;
        #1;
        check("async_reset", 128'({a_state, a_valid, a_busy, a_done, a_img, a_row, a_col}),
              128'({ST_IDLE, 1'b0, 1'b0, 1'b0, 4'd15, 32'd0, 32'd0}));
        win_ready = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        run_vec(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
